// File: rtl/hex_event_drain.sv
// Drains one frame of packed hex events from a synchronous-read memory into a
// 4-entry FIFO, dropping material-0 words and counting emitted/skipped events.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for start; counters hold last frame's totals
// S_READ   | issuing reads 0..N-1 while the FIFO window allows
// S_DRAIN  | all reads issued; waiting for in-flight data and FIFO to empty
// S_DONE   | one-cycle completion, done high
module hex_event_drain #(
   parameter int WIDTH  = 64,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [31:0]         count,
   output logic                rd_en,
   output logic [ADDR_W-1:0]   rd_addr,
   input  logic [WIDTH-1:0]    rd_data,
   output logic                out_valid,
   input  logic                out_ready,
   output logic signed [15:0]  out_q,
   output logic signed [15:0]  out_r,
   output logic [7:0]          out_depth,
   output logic [7:0]          out_material,
   output logic                busy,
   output logic                done,
   output logic [31:0]         emitted_count,
   output logic [31:0]         skipped_count
);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

   localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_N   = (ADDR_W+1)'(1);

   state_t            state;
   logic [ADDR_W:0]   n_words;
   logic [ADDR_W:0]   rd_ptr;
   logic [ADDR_W:0]   n_clamp;
   logic              in_flight;
   logic [47:0]       fifo_mem [4];
   logic [1:0]        wr_idx;
   logic [1:0]        rd_idx;
   logic [2:0]        occ;
   logic [47:0]       head;
   logic [7:0]        cap_material;
   logic              push;
   logic              skip;
   logic              pop;
   logic              last_issue;
   logic              unused_data;

   assign n_clamp      = (count > 32'(DEPTH)) ? DEPTH_N : count[ADDR_W:0];
   assign cap_material = rd_data[23:16];
   assign push         = in_flight && (cap_material != 8'd0);
   assign skip         = in_flight && (cap_material == 8'd0);
   assign pop          = out_valid && out_ready;
   assign unused_data  = ^rd_data;

   // Reads are throttled so every in-flight word is guaranteed a FIFO slot.
   assign rd_en = (state == S_READ) && (rd_ptr < n_words) &&
                  (({1'b0, occ} + {3'b000, in_flight}) < 4'd4);
   assign rd_addr    = rd_ptr[ADDR_W-1:0];
   assign last_issue = rd_en && ((rd_ptr + ONE_N) == n_words);

   assign out_valid    = (occ != 3'd0);
   assign head         = fifo_mem[rd_idx];
   assign out_q        = out_valid ? head[47:32] : 16'sd0;
   assign out_r        = out_valid ? head[31:16] : 16'sd0;
   assign out_depth    = out_valid ? head[15:8]  : 8'd0;
   assign out_material = out_valid ? head[7:0]   : 8'd0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= S_IDLE;
         n_words <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  n_words <= n_clamp;
                  busy    <= 1'b1;
                  state   <= S_READ;
               end
            end
            S_READ: begin
               if ((n_words == '0) || last_issue) state <= S_DRAIN;
            end
            S_DRAIN: begin
               if (!in_flight && (occ == 3'd0)) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr        <= '0;
         in_flight     <= 1'b0;
         occ           <= 3'd0;
         wr_idx        <= 2'd0;
         rd_idx        <= 2'd0;
         emitted_count <= 32'd0;
         skipped_count <= 32'd0;
      end else begin
         in_flight <= rd_en;
         if ((state == S_IDLE) && start) rd_ptr <= '0;
         else if (rd_en)                 rd_ptr <= rd_ptr + ONE_N;

         if (push) wr_idx <= wr_idx + 2'd1;
         if (pop)  rd_idx <= rd_idx + 2'd1;
         occ <= occ + {2'b00, push} - {2'b00, pop};

         if ((state == S_IDLE) && start) begin
            emitted_count <= 32'd0;
            skipped_count <= 32'd0;
         end else begin
            if (pop)  emitted_count <= emitted_count + 32'd1;
            if (skip) skipped_count <= skipped_count + 32'd1;
         end
      end
   end

   // Payload storage needs no reset; occupancy alone defines what is valid.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_idx] <= rd_data[63:16];
   end

endmodule

// File: tb/tb_hex_event_drain.sv
// Randomized bench for hex_event_drain: a queue-based event model predicts
// output order, counters, read addresses and the read window every cycle.
module tb_hex_event_drain;
   localparam int WIDTH  = 64;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   logic               clk = 1'b0;
   logic               reset_n;
   logic               start;
   logic [31:0]        count;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic [WIDTH-1:0]   rd_data = '0;
   logic               out_valid;
   logic               out_ready;
   logic signed [15:0] out_q;
   logic signed [15:0] out_r;
   logic [7:0]         out_depth;
   logic [7:0]         out_material;
   logic               busy;
   logic               done;
   logic [31:0]        emitted_count;
   logic [31:0]        skipped_count;

   hex_event_drain #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .count(count),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_q(out_q), .out_r(out_r), .out_depth(out_depth), .out_material(out_material),
      .busy(busy), .done(done), .emitted_count(emitted_count), .skipped_count(skipped_count)
   );

   always #5 clk = ~clk;

   logic [63:0] mem [DEPTH];
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model state
   bit          m_busy = 0;
   int          m_n, m_next, m_issued, m_acc, m_cap_nz, m_cap_z, m_tot_nz, m_tot_z, m_since;
   int          first_rd, first_ov, done_since;
   logic [47:0] first_ev;
   bit          p1_v, p1_z, p2_v, p2_z;
   logic [47:0] expq [$];

   always @(negedge clk) begin
      bit was_busy;
      if (!reset_n) begin
         m_busy = 0; expq.delete();
         p1_v = 0; p2_v = 0; p1_z = 0; p2_z = 0;
         m_acc = 0; m_cap_nz = 0; m_cap_z = 0; m_issued = 0; m_next = 0;
      end else begin
         was_busy = m_busy;
         if (m_busy) m_since++;
         if (p2_v) begin
            if (p2_z) m_cap_z++;
            else      m_cap_nz++;
         end
         p2_v = p1_v; p2_z = p1_z;

         check("out_valid", out_valid, (m_cap_nz - m_acc) > 0);
         if (out_valid) begin
            if (first_ov < 0) begin first_ov = m_since; first_ev = {out_q, out_r, out_depth, out_material}; end
            if (expq.size() == 0) check("event_unexpected", 1, 0);
            else check("event_fields", {out_q, out_r, out_depth, out_material}, expq[0]);
         end
         check("emitted_count", emitted_count, m_acc);
         check("skipped_count", skipped_count, m_cap_z);
         check("busy", busy, m_busy);

         if (rd_en) begin
            if (first_rd < 0) first_rd = m_since;
            check("rd_addr", rd_addr, m_next);
            check("rd_in_range", m_busy && (m_next < m_n), 1);
            check("rd_window", (m_cap_nz - m_acc + int'(p2_v)) < 4, 1);
            p1_v = 1;
            p1_z = (m_next < DEPTH) ? (mem[m_next][23:16] == 8'd0) : 1'b0;
            m_next++; m_issued++;
         end else p1_v = 0;

         if (done) begin
            done_since = m_since;
            check("done_expected", m_busy, 1);
            check("done_emitted", emitted_count, m_tot_nz);
            check("done_skipped", skipped_count, m_tot_z);
            check("done_sum_n", emitted_count + skipped_count, m_n);
            check("done_reads", m_issued, m_n);
            check("done_queue_empty", expq.size(), 0);
            if (m_n == 0) check("zero_done_latency", m_since <= 3, 1);
         end

         if (out_valid && out_ready) begin
            if (expq.size() != 0) void'(expq.pop_front());
            m_acc++;
         end

         if (start && !was_busy) begin
            m_n = (count > 32'(DEPTH)) ? DEPTH : int'(count);
            expq.delete(); m_tot_z = 0;
            for (int i = 0; i < m_n; i++) begin
               if (mem[i][23:16] != 8'd0) expq.push_back(mem[i][63:16]);
               else m_tot_z++;
            end
            m_tot_nz = expq.size();
            m_next = 0; m_issued = 0; m_acc = 0; m_cap_nz = 0; m_cap_z = 0;
            p1_v = 0; p2_v = 0;
            first_rd = -1; first_ov = -1; done_since = -1;
            m_busy = 1; m_since = 0;
         end
         if (done) m_busy = 0;
      end
   end

   function automatic logic [63:0] word(int q, int r, int d, int m);
      logic [31:0] qv, rv, dv, mv;
      qv = q; rv = r; dv = d; mv = m;
      return {qv[15:0], rv[15:0], dv[7:0], mv[7:0], 16'hA5C3};
   endfunction

   task automatic fill(input bit allow_zero);
      for (int i = 0; i < DEPTH; i++) begin
         logic [63:0] w;
         w = {$urandom, $urandom};
         if (allow_zero && ($urandom % 4 == 0)) w[23:16] = 8'd0;
         else if (w[23:16] == 8'd0) w[23:16] = 8'd1;
         mem[i] = w;
      end
   endtask

   // mode 0: ready high, 1: random ready, 2: ready low 8 cycles then high
   task automatic run_frame(input int cnt, input int mode, input bit repulse);
      bit finished;
      finished = 0;
      @(posedge clk); #1;
      count = cnt; start = 1'b1;
      out_ready = (mode == 2) ? 1'b0 : ((mode == 1) ? 1'($urandom % 2) : 1'b1);
      @(posedge clk); #1;
      start = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (!m_busy) begin finished = 1; break; end
         start = 1'b0;
         if (repulse && c == 3) begin count = 7; start = 1'b1; end
         if (mode == 1) out_ready = 1'($urandom % 2);
         if (mode == 2) begin
            if (c == 7) check("stall_reads_held", m_issued, 4);
            out_ready = (c >= 7);
         end
      end
      start = 1'b0;
      if (!finished) check("frame_timeout", 1, 0);
   endtask

   initial begin
      reset_n = 1'b0; start = 1'b0; count = 32'd0; out_ready = 1'b1;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      #3;
      check("reset_outputs", {rd_en, out_valid, busy, done, rd_addr, out_q, out_r, out_depth, out_material}, 64'd0);
      check("reset_counts", {emitted_count, skipped_count}, 64'd0);
      @(posedge clk); #1 reset_n = 1'b1;

      // three-word frame with literal field and latency expectations
      mem[0] = word(1, -1, 5, 2); mem[1] = word(-2, 3, 9, 7); mem[2] = word(0, 0, 1, 1);
      run_frame(3, 0, 0);
      check("lit_first_rd_cycle", first_rd, 1);
      check("lit_first_valid_cycle", first_ov, 3);
      check("lit_first_event", first_ev, {16'h0001, 16'hFFFF, 8'd5, 8'd2});
      check("lit_emitted_3", emitted_count, 3);
      check("lit_skipped_0", skipped_count, 0);

      // material-0 word at address 2
      mem[3] = word(4, 4, 4, 4); mem[2] = word(8, 8, 8, 0);
      run_frame(4, 0, 0);
      check("lit_skip_emitted", emitted_count, 3);
      check("lit_skip_skipped", skipped_count, 1);

      fill(0);
      run_frame(10, 2, 0);
      check("lit_stall_emitted", emitted_count, 10);

      fill(1);
      run_frame(300, 0, 0);
      check("lit_clamp_reads", m_issued, 256);
      check("lit_clamp_sum", emitted_count + skipped_count, 256);

      run_frame(0, 0, 0);
      check("lit_zero_reads", m_issued, 0);
      check("lit_zero_done_cycle", done_since, 3);

      fill(1);
      run_frame(6, 1, 1);
      check("lit_repulse_sum", emitted_count + skipped_count, 6);

      // reset mid-frame after five events
      fill(0);
      @(posedge clk); #1;
      count = 10; start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 100 && m_acc < 5; c++) begin @(posedge clk); #1; end
      check("mid_reset_progress", m_acc, 5);
      #2 reset_n = 1'b0;
      #1;
      check("mid_reset_outputs", {rd_en, out_valid, busy, done, rd_addr, out_q, out_r, out_depth, out_material}, 64'd0);
      check("mid_reset_counts", {emitted_count, skipped_count}, 64'd0);
      @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
      repeat (3) @(posedge clk);
      #1 check("idle_after_reset", {busy, done, rd_en}, 3'b000);
      run_frame(2, 0, 0);
      check("lit_post_reset_emitted", emitted_count, 2);

      for (int f = 0; f < 15; f++) begin
         fill(1);
         run_frame(($urandom % 8 == 0) ? 300 : int'($urandom_range(0, 24)), 1, ($urandom % 3 == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
